subbytes_engine: RTL and testbench

- Parametrised, folded SubBytes unit for the AES-256 datapath; successor to the fully parallel 16-S-box combinational SubBytes.
- Applies the forward S-box (encrypt) or the inverse S-box (decrypt) to a 128-bit state, LANES bytes per cycle.
- The valid/ready handshake on both sides lets the round controller trade area (LANES=1) against latency (LANES=16).

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_sbox_fi.sv | 12 +
 rtl/subbytes_engine.sv | 113 +++++++++++
 tb/tb_subbytes_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, forward/inverse S-box tables and the SubBytes engine state type.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sb_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] i_val, input logic i_inv);
    return i_inv ? INV_SBOX[i_val] : SBOX[i_val];
  endfunction

endpackage

// File: rtl/aes_sbox_fi.sv
// Single-byte forward/inverse S-box; also used by key-expansion SubWord.
module aes_sbox_fi
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_lookup(i_byte, i_inv);

endmodule

// File: rtl/subbytes_engine.sv
// Folded AES SubBytes: LANES S-boxes applied per cycle over a 128-bit block,
// valid/ready on both sides, registered result held until consumed.
//
// state   | meaning
// IDLE    | waiting for a block, in_ready high
// RUN     | substituting one LANES-byte chunk per cycle
// DONE    | result on out_data, waiting for out_ready
module subbytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int NCHUNK = AES_BYTES / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sb_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [AES_BLOCK_W-1:0] r_work;
  logic [AES_BLOCK_W-1:0] r_out_data;
  logic                   r_inv;
  logic                   r_out_valid;
  logic                   r_busy;

  logic [7:0]             w_lane_in  [LANES];
  logic [7:0]             w_lane_out [LANES];
  logic [AES_BLOCK_W-1:0] w_work_next;
  logic                   w_last;

  // Byte k of the block sits at bits [127-8k -: 8]; chunk r_cnt covers bytes r_cnt*LANES upward.
  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_work[(AES_BLOCK_W - 1) - 8 * (int'(r_cnt) * LANES + l) -: 8];
      w_work_next[(AES_BLOCK_W - 1) - 8 * (int'(r_cnt) * LANES + l) -: 8] = w_lane_out[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_fi u_sbox (
      .i_byte (w_lane_in[l]),
      .i_inv  (r_inv),
      .o_byte (w_lane_out[l])
    );
  end

  assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_inv       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= in_data;
            r_inv   <= in_inv;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + 1'b1;
          // Output register loads only here so out_data never shows a partial block.
          if (w_last) begin
            r_out_data  <= w_work_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_subbytes_engine.sv
// Directed bench for subbytes_engine: LANES=4, 1 and 16 builds driven side by side.
module tb_subbytes_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0]        in_valid  = '0;
  logic [2:0]        in_inv    = '0;
  logic [2:0]        out_ready = '0;
  logic [2:0]        in_ready;
  logic [2:0]        out_valid;
  logic [2:0]        busy;
  logic [2:0][127:0] in_data   = '0;
  logic [2:0][127:0] out_data;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] VEC_PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VEC_SUB = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_00  = 128'h0;
  localparam logic [127:0] ALL_63  = {16{8'h63}};
  localparam logic [127:0] ALL_53  = {16{8'h53}};
  localparam logic [127:0] ALL_ED  = {16{8'hed}};

  always #5 clk = ~clk;

  subbytes_engine #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  subbytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  subbytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_inv(in_inv[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("%s FAIL observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input int d, input int n0, input int exp_lat,
                             input logic [127:0] exp, input bit scramble);
    int n;
    n = n0;
    while (!out_valid[d] && n < 40) begin
      @(negedge clk);
      if (scramble) begin
        in_data[d] = ~in_data[d] ^ {$urandom, $urandom, $urandom, $urandom};
        in_inv[d]  = ~in_inv[d];
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 128'(n), 128'(exp_lat));
    check("result", out_data[d], exp);
  endtask

  task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                           input int exp_lat, input logic [127:0] exp, input bit scramble);
    @(negedge clk);
    in_valid[d]  = 1'b1;
    in_data[d]   = data;
    in_inv[d]    = inv;
    out_ready[d] = 1'b0;
    @(posedge clk); #1;
    in_valid[d] = scramble;
    check("accept_busy", 128'(busy[d]), 128'd1);
    check("accept_in_ready", 128'(in_ready[d]), 128'd0);
    wait_result(d, 1, exp_lat, exp, scramble);
  endtask

  task automatic consume(input int d);
    @(negedge clk);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    check("consume_out_valid", 128'(out_valid[d]), 128'd0);
    check("consume_in_ready", 128'(in_ready[d]), 128'd1);
    check("consume_busy", 128'(busy[d]), 128'd0);
    out_ready[d] = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", 128'(out_valid[d]), 128'd0);
      check("rst_out_data", out_data[d], 128'd0);
      check("rst_busy", 128'(busy[d]), 128'd0);
      check("rst_in_ready", 128'(in_ready[d]), 128'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // LANES=4 forward and inverse vectors
    run_block(0, VEC_PT, 1'b0, 5, VEC_SUB, 1'b0);
    consume(0);
    run_block(0, VEC_SUB, 1'b1, 5, VEC_PT, 1'b0);
    consume(0);

    // LANES=1 and LANES=16 builds
    run_block(1, ALL_00, 1'b0, 17, ALL_63, 1'b0);
    consume(1);
    run_block(1, ALL_63, 1'b1, 17, ALL_00, 1'b0);
    consume(1);
    run_block(2, ALL_00, 1'b0, 2, ALL_63, 1'b0);
    consume(2);
    run_block(2, ALL_63, 1'b1, 2, ALL_00, 1'b0);
    consume(2);

    // back-pressure, then consume and offer a new block in the same cycle
    run_block(0, VEC_PT, 1'b0, 5, VEC_SUB, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
      check("bp_out_data", out_data[0], VEC_SUB);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = ALL_53;
    in_inv[0]    = 1'b0;
    @(posedge clk); #1;
    check("bp_consumed_out_valid", 128'(out_valid[0]), 128'd0);
    check("bp_not_yet_accepted", 128'(in_ready[0]), 128'd1);
    check("bp_idle_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp_accepted_in_ready", 128'(in_ready[0]), 128'd0);
    check("bp_accepted_busy", 128'(busy[0]), 128'd1);
    wait_result(0, 1, 5, ALL_ED, 1'b0);
    consume(0);

    // reset while RUN has cnt=1
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = VEC_PT;
    in_inv[0]   = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("run_out_data_held", out_data[0], ALL_ED);
    check("run_out_valid", 128'(out_valid[0]), 128'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst_out_data", out_data[0], 128'd0);
    check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    check("midrst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, ALL_53, 1'b0, 5, ALL_ED, 1'b0);
    consume(0);

    // in_data / in_inv toggling after acceptance must not leak into the result
    run_block(0, VEC_PT, 1'b0, 5, VEC_SUB, 1'b1);
    consume(0);
    run_block(0, VEC_SUB, 1'b1, 5, VEC_PT, 1'b1);
    consume(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
